// File: rtl/riscv_dbus_slave.sv
// Data-bus slave: store buffer in front of a single-port SRAM with
// byte-lane forwarding from buffered writes to reads.
module riscv_dbus_slave #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req,
  input  logic [3:0]                  rd_be,
  input  logic [31:0]                 rd_addr,
  output logic [31:0]                 rd_data,
  input  logic                        wr_req,
  input  logic [3:0]                  wr_be,
  input  logic [31:0]                 wr_addr,
  input  logic [31:0]                 wr_data,
  output logic                        bus_stall,
  output logic                        sram_en,
  output logic [3:0]                  sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [31:0]                 sram_wdata,
  input  logic [31:0]                 sram_rdata,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);

  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [3:0]        sb_be_q   [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [3:0]    fwd_mask_q, fwd_mask_d;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [ADDR_W-1:0] rd_waddr;
  logic [ADDR_W-1:0] wr_waddr;
  logic              full;
  logic              rd_acc;
  logic              wr_acc;
  logic              drain;
  logic [PW-1:0]     idx;
  logic              unused_ok;

  assign rd_waddr  = rd_addr[ADDR_W+1:2];
  assign wr_waddr  = wr_addr[ADDR_W+1:2];
  assign full      = (cnt_q == FULL);
  assign bus_stall = full && (rd_req || wr_req);
  assign rd_acc    = rd_req && !bus_stall;
  assign wr_acc    = wr_req && !bus_stall && (wr_be != 4'b0);
  assign drain     = (cnt_q != '0) && !rd_acc;
  assign sb_empty  = (cnt_q == '0);
  assign sb_count  = cnt_q;
  assign unused_ok = ^{rd_be, rd_addr[31:ADDR_W+2], rd_addr[1:0],
                       wr_addr[31:ADDR_W+2], wr_addr[1:0]};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (wr_acc) tail_d = tail_q + 1'b1;
    if (drain)  head_d = head_q + 1'b1;
    unique case ({wr_acc, drain})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Walk oldest to youngest so the youngest match wins each lane.
  always_comb begin
    fwd_mask_d = 4'b0;
    fwd_data_d = 32'b0;
    idx        = head_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < cnt_q) && (sb_addr_q[idx] == rd_waddr)) begin
        for (int l = 0; l < 4; l++) begin
          if (sb_be_q[idx][l]) begin
            fwd_mask_d[l]        = 1'b1;
            fwd_data_d[l*8 +: 8] = sb_data_q[idx][l*8 +: 8];
          end
        end
      end
    end
    rd_pend_d = rd_acc;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_pend_q) begin
      for (int l = 0; l < 4; l++) begin
        rd_data_d[l*8 +: 8] = fwd_mask_q[l] ? fwd_data_q[l*8 +: 8]
                                            : sram_rdata[l*8 +: 8];
      end
    end
  end

  assign rd_data = rd_data_d;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0;
    sram_addr  = rd_waddr;
    sram_wdata = sb_data_q[head_q];
    unique case (1'b1)
      rd_acc: begin
        sram_en   = 1'b1;
        sram_addr = rd_waddr;
      end
      drain: begin
        sram_en   = 1'b1;
        sram_we   = sb_be_q[head_q];
        sram_addr = sb_addr_q[head_q];
      end
      default: ;
    endcase
    if (!rst_n) begin
      sram_en = 1'b0;
      sram_we = 4'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      fwd_mask_q <= 4'b0;
      fwd_data_q <= 32'b0;
      rd_data_q  <= 32'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      sb_addr_q[tail_q] <= wr_waddr;
      sb_be_q[tail_q]   <= wr_be;
      sb_data_q[tail_q] <= wr_data;
    end
  end

endmodule

// File: doc/riscv_dbus_slave.md
RISCV_DBUS_SLAVE -- requirements
Module: riscv_dbus_slave

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning SRAM word-address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rd_req in 1, rd_be in 4, rd_addr in 32  read request, byte enables, word-aligned byte address.
REQ-006 SHALL have port rd_data  output  32  read word, valid in the cycle after acceptance.
REQ-007 SHALL have ports wr_req in 1, wr_be in 4, wr_addr in 32, wr_data in 32  write request, lane-aligned data.
REQ-008 SHALL have port bus_stall  output  1  high means no request accepted this cycle.
REQ-009 SHALL have ports sram_en out 1, sram_we out 4, sram_addr out ADDR_W, sram_wdata out 32  single-port SRAM command.
REQ-010 SHALL have port sram_rdata  input  32  SRAM read data, one-cycle latency after sram_en with sram_we==0.
REQ-011 SHALL have ports sb_empty out 1, sb_count out $clog2(SB_DEPTH)+1  buffer status for fence logic.

Function
REQ-012 Word address SHALL be addr[ADDR_W+1:2]; addr[1:0] and address bits above ADDR_W+1 ignored.
REQ-013 Store buffer SHALL be a FIFO of {word addr, be, data}, with head and tail pointers wrapping modulo SB_DEPTH.
REQ-014 bus_stall SHALL be combinational: 1 when sb_count==SB_DEPTH and (rd_req or wr_req), else 0.
REQ-015 A write with wr_req=1, bus_stall=0, wr_be!=0 SHALL enqueue at the tail in that cycle; wr_be==0 SHALL be accepted and discarded.
REQ-016 A read with rd_req=1, bus_stall=0 SHALL drive sram_en=1, sram_we=0, sram_addr=word addr in cycle N.
REQ-017 Drain (head entry to SRAM: sram_en=1, sram_we=be, sram_addr, sram_wdata) SHALL occur in any cycle with buffer non-empty and no accepted read, including every stalled cycle.
REQ-018 Priority per cycle SHALL be: forced drain when full > accepted read > opportunistic drain; the SRAM port carries at most one command.
REQ-019 Enqueue and drain in the same cycle SHALL leave sb_count unchanged; count is never below 0 nor above SB_DEPTH.
REQ-020 Forwarding: at acceptance (cycle N), per byte lane, the youngest buffer entry matching the word address with that be bit set SHALL supply the lane; lane mask and bytes registered.
REQ-021 In cycle N+1, rd_data per lane SHALL be forwarded byte if masked, else sram_rdata byte; full 32-bit word returned regardless of rd_be.
REQ-022 A write accepted in the same cycle as a read to the same word SHALL NOT be visible to that read (read sees pre-write state).
REQ-023 When no read was accepted in the previous cycle, rd_data SHALL hold its last returned value.
REQ-024 sb_empty SHALL be 1 exactly when sb_count==0.
REQ-025 sram_en=0, sram_we=0 in cycles with no read and no drain; sram_addr/sram_wdata don't-care then.

Reset
REQ-026 On rst_n low SHALL clear pointers, sb_count=0, sb_empty=1, pending-read flag=0, rd_data=0, forward mask=0, asynchronously.
REQ-027 Reset mid-operation SHALL discard buffered writes without draining; sram_en=0 while rst_n low.
REQ-028 Buffer payload registers need no reset.

Verification
REQ-029 Write 0x1000 be=1111 data=0xDEADBEEF, idle 1 cycle -> SRAM write at word 0x400, sb_empty=1 after.
REQ-030 Write 0x1000 be=0001 data=0x000000AA while rd_req held every cycle; then read 0x1000 with SRAM=0x11223344 -> rd_data=0x112233AA.
REQ-031 Two writes to 0x2004: be=0011 0x5555, then be=0001 0x77; read -> lanes[15:0]=0x5577, upper lanes from SRAM.
REQ-032 Fill SB_DEPTH writes under continuous reads, issue another write -> bus_stall=1 one cycle, head drained, write accepted next cycle, count=SB_DEPTH.
REQ-033 Same-cycle read and write to 0x3000 (SRAM=0x0, buffer empty) -> rd_data=0x00000000; subsequent read -> written value.
REQ-034 Assert rst_n low with 3 buffered entries -> sb_count=0, rd_data=0, no SRAM write issued afterwards.
